// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
// Provides the FSM state enum, the fault instruction word, the LFSR seed
// and the byte-address range/alignment check used for requests and preloads.
package imem_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESP
  } imem_state_t;

  localparam logic [31:0] FAULT_INST = 32'h0000_0000;
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;

  // True when addr is word-aligned and inside [base, base + 4*depth).
  // The subtraction wraps for addr < base, which lands far above the limit.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int unsigned depth);
    logic [33:0] off;
    logic [33:0] lim;
    off = {2'b00, addr - base};
    lim = {depth, 2'b00};
    return (addr[1:0] == 2'b00) && (off < lim);
  endfunction

endpackage

// File: rtl/imem_lfsr.sv
// imem_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifts left with the
// feedback entering bit 0; seeded on reset, steps once per 'advance' pulse.
// Ports: clock, reset (sync, active-high), advance in, value[7:0] out (registered).
module imem_lfsr
  import imem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch-side instruction store; answers one-cycle read pulses
// after LATENCY cycles (plus lfsr[2:0] extra cycles when IMEM_RAND_DELAY_EN is
// defined), with a preload write port and a sticky error flag.
// Ports: clock/reset (sync, active-high); io_reqValid/io_addr request in;
// io_respValid/io_rdata response out; load_wen/load_addr/load_wdata preload in;
// busy (WAIT or RESP) and err (sticky) out. All outputs are registered.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_reqValid,
  input  logic [31:0] io_addr,
  output logic        io_respValid,
  output logic [31:0] io_rdata,
  input  logic        load_wen,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  // Wide enough for the largest load value, LATENCY-1+7.
  localparam int unsigned CW = $clog2(LATENCY + 8);

  logic [31:0] mem [DEPTH_WORDS];

  imem_state_t   state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] cap_idx;
  logic          cap_fault;

  logic          accept;
  logic [2:0]    extra;
  logic [CW-1:0] load_cnt;
  logic [IW-1:0] req_idx;
  logic          req_fault;
  logic [IW-1:0] load_idx;
  logic          load_ok;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic          rd_fault;

  // A request is taken in IDLE and in the RESP cycle; in WAIT it is a violation.
  assign accept    = io_reqValid && (state != IMEM_WAIT);
  assign req_fault = !addr_ok(io_addr, BASE_ADDR, DEPTH_WORDS);
  assign req_idx   = IW'((io_addr - BASE_ADDR) >> 2);
  assign load_ok   = addr_ok(load_addr, BASE_ADDR, DEPTH_WORDS);
  assign load_idx  = IW'((load_addr - BASE_ADDR) >> 2);

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_value;

  // Extra delay uses the value before this request's advance.
  imem_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr_value)
  );

  assign extra = lfsr_value[2:0];
`else
  assign extra = 3'd0;
`endif

  assign load_cnt = CW'(LATENCY - 1) + CW'(extra);

  // The array is read on the edge that enters RESP: either straight from an
  // accept with a zero wait (uses the live address) or at the end of WAIT
  // (uses the captured index).
  always_comb begin
    rd_en    = 1'b0;
    rd_idx   = cap_idx;
    rd_fault = cap_fault;
    if (accept && (load_cnt == '0)) begin
      rd_en    = 1'b1;
      rd_idx   = req_idx;
      rd_fault = req_fault;
    end else if ((state == IMEM_WAIT) && (cnt == CW'(1))) begin
      rd_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IMEM_IDLE;
      cnt          <= '0;
      cap_idx      <= '0;
      cap_fault    <= 1'b0;
      io_respValid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      io_respValid <= 1'b0;
      case (state)
        IMEM_IDLE, IMEM_RESP: begin
          if (io_reqValid) begin
            cap_idx   <= req_idx;
            cap_fault <= req_fault;
            busy      <= 1'b1;
            if (req_fault) err <= 1'b1;
            if (load_cnt == '0) begin
              state        <= IMEM_RESP;
              io_respValid <= 1'b1;
            end else begin
              state <= IMEM_WAIT;
              cnt   <= load_cnt;
            end
          end else begin
            state <= IMEM_IDLE;
            busy  <= 1'b0;
          end
        end
        IMEM_WAIT: begin
          // Stray request here is dropped; the pending response continues.
          if (io_reqValid) err <= 1'b1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state        <= IMEM_RESP;
            io_respValid <= 1'b1;
          end
        end
        default: begin
          state <= IMEM_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (load_wen && !load_ok) err <= 1'b1;
    end
  end

  // Preload writes are accepted in every state, including during reset.
  always_ff @(posedge clock) begin
    if (load_wen && load_ok) begin
      mem[load_idx] <= load_wdata;
    end
  end

  // Registered read; a same-edge write to rd_idx is not seen (old data).
  always_ff @(posedge clock) begin
    if (reset) begin
      io_rdata <= '0;
    end else if (rd_en) begin
      io_rdata <= rd_fault ? FAULT_INST : mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: drives directed and randomized traffic into imem_responder
// and compares every cycle against a due-cycle based behavioural model.
// Define IMEM_RAND_DELAY_EN for both bench and RTL to cover the random delay.
module tb_imem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned LAT   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_reqValid;
  logic [31:0] io_addr;
  logic        io_respValid;
  logic [31:0] io_rdata;
  logic        load_wen;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: one outstanding response, due in cycle m_due.
  bit          m_pend = 1'b0;
  int          m_due = 0;
  int          m_idx = 0;
  bit          m_fault = 1'b0;
  logic [7:0]  m_lfsr = 8'hA5;
  logic [31:0] mem_m [DEPTH];
  bit          e_resp = 1'b0;
  logic [31:0] e_rdata = '0;
  bit          e_busy = 1'b0;
  bit          e_err = 1'b0;

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_reqValid  (io_reqValid),
    .io_addr      (io_addr),
    .io_respValid (io_respValid),
    .io_rdata     (io_rdata),
    .load_wen     (load_wen),
    .load_addr    (load_addr),
    .load_wdata   (load_wdata),
    .busy         (busy),
    .err          (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void addr_chk(input logic [31:0] a, output bit ok, output int idx);
    longint lo, hi, av;
    lo  = longint'(BASE);
    hi  = lo + 4 * longint'(DEPTH);
    av  = longint'(a);
    ok  = (a % 4 == 0) && (av >= lo) && (av < hi);
    idx = ok ? int'((av - lo) / 4) : 0;
  endfunction

  // Advance the model across the clock edge that ends cycle 'cyc'.
  task automatic model_step(input bit rst, input bit rv, input logic [31:0] ad,
                            input bit lw, input logic [31:0] la, input logic [31:0] ld);
    bit ok;
    int idx;
    int lat;
    if (rst) begin
      m_pend = 1'b0;
      e_resp = 1'b0;
      e_rdata = '0;
      e_busy = 1'b0;
      e_err = 1'b0;
      m_lfsr = 8'hA5;
    end else begin
      if (rv) begin
        if (!m_pend || m_due == cyc) begin
          lat = LAT;
`ifdef IMEM_RAND_DELAY_EN
          lat = lat + int'(m_lfsr % 8);
          m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
          addr_chk(ad, ok, idx);
          m_pend  = 1'b1;
          m_due   = cyc + lat;
          m_idx   = idx;
          m_fault = !ok;
          if (!ok) e_err = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end else if (m_pend && m_due == cyc) begin
        m_pend = 1'b0;
      end
      e_resp = m_pend && (m_due == cyc + 1);
      e_busy = m_pend && (m_due >= cyc + 1);
      if (e_resp) e_rdata = m_fault ? 32'h0 : mem_m[m_idx];
    end
    if (lw) begin
      addr_chk(la, ok, idx);
      if (ok) mem_m[idx] = ld;
      else if (!rst) e_err = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, step the model, cross the edge and compare.
  task automatic tick(input bit rst, input bit rv, input logic [31:0] ad,
                      input bit lw, input logic [31:0] la, input logic [31:0] ld);
    reset       = rst;
    io_reqValid = rv;
    io_addr     = ad;
    load_wen    = lw;
    load_addr   = la;
    load_wdata  = ld;
    model_step(rst, rv, ad, lw, la, ld);
    @(posedge clock);
    #1;
    cyc++;
    chk("resp_valid", 32'(io_respValid), 32'(e_resp));
    chk("rdata", io_rdata, e_rdata);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("err", 32'(err), 32'(e_err));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic req(input logic [31:0] a);
    tick(1'b0, 1'b1, a, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       return BASE + 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
      1:       return BASE - 32'(4 * $urandom_range(1, 8));
      2:       return BASE + 32'(4 * (DEPTH + $urandom_range(0, 8)));
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    int k;
    do_reset();
    chk("reset_resp", 32'(io_respValid), 32'h0);
    chk("reset_rdata", io_rdata, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    for (int i = 0; i < int'(DEPTH); i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1, BASE + 32'(4 * i), $urandom);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 32'h0050_0093);
    tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0004, 32'h0000_0013);

`ifndef IMEM_RAND_DELAY_EN
    // Basic read and back-to-back.
    req(32'h8000_0000);
    chk("t1_busy_t1", 32'(busy), 32'h1);
    chk("t1_resp_t1", 32'(io_respValid), 32'h0);
    idle();
    chk("t1_resp_t2", 32'(io_respValid), 32'h1);
    chk("t1_rdata", io_rdata, 32'h0050_0093);
    chk("t1_busy_t2", 32'(busy), 32'h1);
    req(32'h8000_0004);
    chk("t2_resp_t3", 32'(io_respValid), 32'h0);
    chk("t2_busy_t3", 32'(busy), 32'h1);
    idle();
    chk("t2_resp_t4", 32'(io_respValid), 32'h1);
    chk("t2_rdata", io_rdata, 32'h0000_0013);
    idle();
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // Address faults.
    req(32'h8000_0002);
    idle();
    chk("t3_mis_resp", 32'(io_respValid), 32'h1);
    chk("t3_mis_rdata", io_rdata, 32'h0);
    chk("t3_mis_err", 32'(err), 32'h1);
    req(32'h7FFF_FFFC);
    idle();
    chk("t3_low_resp", 32'(io_respValid), 32'h1);
    chk("t3_low_rdata", io_rdata, 32'h0);
    chk("t3_low_err", 32'(err), 32'h1);
    idle();

    // Violation in WAIT.
    do_reset();
    req(32'h8000_0000);
    req(32'h8000_0004);
    chk("t4_resp", 32'(io_respValid), 32'h1);
    chk("t4_rdata", io_rdata, 32'h0050_0093);
    chk("t4_err", 32'(err), 32'h1);
    idle();
    chk("t4_single", 32'(io_respValid), 32'h0);

    // Reset mid-operation.
    req(32'h8000_0004);
    do_reset();
    chk("t5_resp", 32'(io_respValid), 32'h0);
    chk("t5_rdata", io_rdata, 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_err", 32'(err), 32'h0);
    idle();
    req(32'h8000_0000);
    idle();
    chk("t5_fresh_resp", 32'(io_respValid), 32'h1);
    chk("t5_fresh_rdata", io_rdata, 32'h0050_0093);
    idle();
`else
    // First request after reset waits LAT + seed[2:0] = 7 cycles.
    do_reset();
    req(32'h8000_0000);
    k = 1;
    while (!io_respValid && k < 20) begin
      idle();
      k++;
    end
    chk("t6_first_lat", 32'(k), 32'd7);
    chk("t6_first_rdata", io_rdata, 32'h0050_0093);
    for (int n = 0; n < 100; n++) begin
      req(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)));
      k = 1;
      while (!io_respValid && k < 20) begin
        idle();
        k++;
      end
      chk("t6_lat_range", 32'(k >= 2 && k <= 9), 32'h1);
    end
    idle();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 4,
           rand_addr(),
           $urandom_range(0, 4) == 0,
           ($urandom_range(0, 19) == 0) ? rand_addr()
                                        : BASE + 32'(4 * $urandom_range(0, DEPTH - 1)),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
